// File: rtl/arb_egress_buffer.sv
// arb_egress_buffer: captures one-hot grants into an FWFT egress FIFO with per-source grant counters and sticky error flags
module arb_egress_buffer #(
  parameter int NUM_REQS  = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2,
  parameter int CWID      = 16,
  parameter int SIDW      = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQS-1:0]          gnt,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [SIDW-1:0]              out_src,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         almost_full,
  output logic [NUM_REQS*CWID-1:0]     grant_cnts,
  output logic                         err_multi_gnt,
  output logic                         err_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(DEPTH - AF_MARGIN);
  logic [SIDW+WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic [CWID-1:0]       cnt [NUM_REQS];
  logic [SIDW-1:0]       src;
  logic                  any, one_hot, push, pop;
  always_comb begin
    src = '0;
    for (int i = 0; i < NUM_REQS; i++) src = gnt[i] ? SIDW'(i) : src;
  end
  assign any         = |gnt;
  assign one_hot     = any && ((gnt & (gnt - 1'b1)) == '0);
  assign pop         = out_valid && out_ready;
  assign push        = one_hot && (!full || pop);
  assign out_valid   = count != '0;
  assign full        = count == FULL_C;
  assign almost_full = count >= AF_C;
  assign {out_src, out_data} = mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      err_multi_gnt <= 1'b0;
      err_overflow  <= 1'b0;
      for (int i = 0; i < NUM_REQS; i++) cnt[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {src, data_in};
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count         <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
      err_multi_gnt <= err_multi_gnt || (any && !one_hot);
      err_overflow  <= err_overflow || (one_hot && full && !pop);
      for (int i = 0; i < NUM_REQS; i++)
        cnt[i] <= (push && src == SIDW'(i) && !(&cnt[i])) ? cnt[i] + 1'b1 : cnt[i];
    end
  end
  genvar g;
  generate
    for (g = 0; g < NUM_REQS; g++) begin : g_cnt
      assign grant_cnts[g*CWID +: CWID] = cnt[g];
    end
  endgenerate
endmodule

// File: tb/tb_arb_egress_buffer.sv
// tb_arb_egress_buffer: directed stimulus checked every cycle against a queue-based model
module tb_arb_egress_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  gnt = '0;
  logic [7:0]  data_in = '0;
  logic        out_ready = 1'b0;
  logic        valid, full, af, em, eo;
  logic [7:0]  odata;
  logic [1:0]  osrc;
  logic [3:0]  cnt;
  logic [63:0] gc;
  logic        s_valid, s_full, s_af, s_em, s_eo;
  logic [7:0]  s_odata;
  logic [1:0]  s_osrc;
  logic [3:0]  s_cnt;
  logic [7:0]  s_gc;
  logic [9:0]  q [$];
  int          m_cnt [4];
  logic        m_em, m_eo;
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  arb_egress_buffer dut (
    .clk(clk), .rst(rst), .gnt(gnt), .data_in(data_in), .out_ready(out_ready),
    .out_valid(valid), .out_data(odata), .out_src(osrc), .count(cnt),
    .full(full), .almost_full(af), .grant_cnts(gc),
    .err_multi_gnt(em), .err_overflow(eo)
  );
  arb_egress_buffer #(.CWID(2)) u_sat (
    .clk(clk), .rst(rst), .gnt(gnt), .data_in(data_in), .out_ready(out_ready),
    .out_valid(s_valid), .out_data(s_odata), .out_src(s_osrc), .count(s_cnt),
    .full(s_full), .almost_full(s_af), .grant_cnts(s_gc),
    .err_multi_gnt(s_em), .err_overflow(s_eo)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask
  task automatic model_update(input logic [3:0] g, input logic [7:0] d, input logic r, input logic rs);
    int  ones, idx;
    logic pop, acc;
    if (rs) begin
      q.delete();
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_em = 1'b0;
      m_eo = 1'b0;
    end else begin
      pop  = q.size() != 0 && r;
      ones = $countones(g);
      idx  = 0;
      for (int i = 0; i < 4; i++) if (g[i]) idx = i;
      if (ones > 1) m_em = 1'b1;
      acc = ones == 1 && (q.size() < 8 || pop);
      if (ones == 1 && !acc) m_eo = 1'b1;
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back({2'(idx), d});
        m_cnt[idx]++;
      end
    end
  endtask
  task automatic compare();
    int sz;
    sz = q.size();
    chk("out_valid", valid, sz != 0);
    if (sz != 0) begin
      chk("out_data", odata, q[0][7:0]);
      chk("out_src", osrc, q[0][9:8]);
    end
    chk("count", cnt, sz);
    chk("full", full, sz == 8);
    chk("almost_full", af, sz >= 6);
    chk("err_multi_gnt", em, m_em);
    chk("err_overflow", eo, m_eo);
    chk("sat_count", s_cnt, sz);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("grant_cnt%0d", i), gc[i*16 +: 16], m_cnt[i]);
      chk($sformatf("sat_grant_cnt%0d", i), s_gc[i*2 +: 2], m_cnt[i] > 3 ? 3 : m_cnt[i]);
    end
  endtask
  task automatic step(input logic [3:0] g, input logic [7:0] d, input logic r, input logic rs);
    gnt = g; data_in = d; out_ready = r; rst = rs;
    @(posedge clk);
    model_update(g, d, r, rs);
    #1 compare();
  endtask
  initial begin
    step(4'b0000, 8'h00, 1'b0, 1'b1);
    step(4'b0000, 8'h00, 1'b0, 1'b1);
    chk("lit_reset_valid", valid, 0);
    chk("lit_reset_count", cnt, 0);
    chk("lit_reset_gc", gc[31:0], 0);
    step(4'b0100, 8'hA5, 1'b1, 1'b0);
    chk("lit_c1_data", odata, 8'hA5);
    chk("lit_c1_src", osrc, 2);
    step(4'b0001, 8'h3C, 1'b1, 1'b0);
    chk("lit_c2_data", odata, 8'h3C);
    chk("lit_c2_src", osrc, 0);
    step(4'b0000, 8'hFF, 1'b1, 1'b0);
    chk("lit_c3_valid", valid, 0);
    for (int i = 0; i < 8; i++) begin
      step(4'b0010, 8'(8'h10 + i), 1'b0, 1'b0);
      if (i == 4) chk("lit_af_before", af, 0);
      if (i == 5) chk("lit_af_after6", af, 1);
      if (i == 6) chk("lit_full_before", full, 0);
    end
    chk("lit_full_after8", full, 1);
    step(4'b0010, 8'hEE, 1'b0, 1'b0);
    chk("lit_ovf_flag", eo, 1);
    chk("lit_ovf_count", cnt, 8);
    chk("lit_ovf_gc1", gc[31:16], 8);
    chk("lit_ovf_sat_gc1", s_gc[3:2], 3);
    step(4'b1000, 8'h77, 1'b1, 1'b0);
    chk("lit_pushpop_count", cnt, 8);
    chk("lit_pushpop_head", odata, 8'h11);
    for (int i = 0; i < 7; i++) step(4'b0000, 8'h00, 1'b1, 1'b0);
    chk("lit_tail_word", odata, 8'h77);
    chk("lit_tail_src", osrc, 3);
    step(4'b0000, 8'h00, 1'b1, 1'b0);
    chk("lit_drained", valid, 0);
    step(4'b0110, 8'h55, 1'b0, 1'b0);
    chk("lit_multi_flag", em, 1);
    chk("lit_multi_count", cnt, 0);
    step(4'b0000, 8'h00, 1'b1, 1'b0);
    step(4'b0001, 8'h42, 1'b0, 1'b0);
    step(4'b0110, 8'h09, 1'b1, 1'b0);
    chk("lit_multi_pop", cnt, 0);
    chk("lit_multi_sticky", em, 1);
    for (int i = 0; i < 5; i++) step(4'b1000, 8'(8'hC0 + i), 1'b1, 1'b0);
    step(4'b0000, 8'h00, 1'b1, 1'b0);
    chk("lit_sat_gc3", s_gc[7:6], 3);
    chk("lit_full_gc3", gc[63:48], 6);
    step(4'b0100, 8'h01, 1'b0, 1'b0);
    step(4'b0010, 8'h02, 1'b0, 1'b0);
    step(4'b0001, 8'h03, 1'b1, 1'b1);
    chk("lit_rst_count", cnt, 0);
    chk("lit_rst_valid", valid, 0);
    chk("lit_rst_gc", gc[31:0], 0);
    chk("lit_rst_errs", {em, eo}, 0);
    step(4'b0100, 8'hAB, 1'b0, 1'b0);
    chk("lit_post_rst_head", odata, 8'hAB);
    for (int i = 0; i < 12; i++)
      step(4'(1 << (i % 4)), 8'(i * 17), 1'(i % 3 != 0), 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
